// File: rtl/nibble_serial_adder_ctrl_if.sv
// Command/result bundle for nibble_serial_adder_ctrl: valid/ready command port in, valid/ready result port out.
// The op_sub signal exists only when NSADD_SUB_EN is defined.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
`ifdef NSADD_SUB_EN
    logic             op_sub;
`endif
    logic             result_valid;
    logic             result_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;
    logic             busy;

    modport slave (
`ifdef NSADD_SUB_EN
        input  op_sub,
`endif
        input  start_valid, a, b, c_in, result_ready,
        output start_ready, result_valid, sum, c_out, overflow, busy
    );

    modport master (
`ifdef NSADD_SUB_EN
        output op_sub,
`endif
        output start_valid, a, b, c_in, result_ready,
        input  start_ready, result_valid, sum, c_out, overflow, busy
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice reused for WIDTH/4 cycles, low nibble first.
// Optional subtraction (op_sub) is enabled by defining NSADD_SUB_EN.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    nibble_serial_adder_ctrl_if.slave   bus
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Returns {overflow, carry_out, sum[3:0]}; overflow is carry into bit 3 XOR carry out of bit 3.
    function automatic logic [5:0] slice_add(input logic [3:0] x, input logic [3:0] y, input logic ci);
        logic [3:0] low;
        logic [1:0] top;
        low = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, ci};
        top = {1'b0, x[3]} + {1'b0, y[3]} + {1'b0, low[3]};
        return {top[1] ^ low[3], top[1], top[0], low[2:0]};
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
    logic               overflow_q, overflow_d;
    logic               start_ready_q, start_ready_d;
    logic               result_valid_q, result_valid_d;
    logic               busy_q, busy_d;
    logic [5:0]         slice_s;

    // Slice operands are picked straight from the captured operands by the nibble index.
    always_comb begin
        slice_s = slice_add(a_q[{idx_q, 2'b00} +: 4], b_q[{idx_q, 2'b00} +: 4], carry_q);
    end

    // Next-state and datapath update for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        carry_d        = carry_q;
        idx_d          = idx_q;
        sum_d          = sum_q;
        c_out_d        = c_out_q;
        overflow_d     = overflow_q;
        start_ready_d  = start_ready_q;
        result_valid_d = result_valid_q;
        busy_d         = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start_valid && start_ready_q) begin
                    a_d = bus.a;
`ifdef NSADD_SUB_EN
                    // Subtraction is a + ~b + 1, so c_in is replaced by the forced carry.
                    b_d     = bus.op_sub ? ~bus.b : bus.b;
                    carry_d = bus.op_sub ? 1'b1 : bus.c_in;
`else
                    b_d     = bus.b;
                    carry_d = bus.c_in;
`endif
                    idx_d         = '0;
                    state_d       = ST_RUN;
                    start_ready_d = 1'b0;
                    busy_d        = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = slice_s[3:0];
                carry_d                    = slice_s[4];
                if (idx_q == IDX_LAST) begin
                    c_out_d        = slice_s[4];
                    overflow_d     = slice_s[5];
                    idx_d          = '0;
                    state_d        = ST_DONE;
                    result_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.result_ready) begin
                    state_d        = ST_IDLE;
                    result_valid_d = 1'b0;
                    start_ready_d  = 1'b1;
                    busy_d         = 1'b0;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                idx_d          = '0;
                start_ready_d  = 1'b1;
                result_valid_d = 1'b0;
                busy_d         = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            a_q            <= '0;
            b_q            <= '0;
            carry_q        <= 1'b0;
            idx_q          <= '0;
            sum_q          <= '0;
            c_out_q        <= 1'b0;
            overflow_q     <= 1'b0;
            start_ready_q  <= 1'b1;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            carry_q        <= carry_d;
            idx_q          <= idx_d;
            sum_q          <= sum_d;
            c_out_q        <= c_out_d;
            overflow_q     <= overflow_d;
            start_ready_q  <= start_ready_d;
            result_valid_q <= result_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.start_ready  = start_ready_q;
    assign bus.result_valid = result_valid_q;
    assign bus.sum          = sum_q;
    assign bus.c_out        = c_out_q;
    assign bus.overflow     = overflow_q;
    assign bus.busy         = busy_q;
endmodule
